// File: rtl/ser_rx.sv
// Framed serial receiver: active-low sync strobe, PAD_BITS pad bits then DATA_W payload, MSB first.
// Define SER_RX_CTRL_CHECK_EN to reject full frames whose pad bits are nonzero.
module ser_rx #(
  parameter int DATA_W   = 16,
  parameter int PAD_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdi,
  input  logic              sync,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam int FRAME_LEN = PAD_BITS + DATA_W;
  localparam logic [4:0] LEN5 = 5'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OVERRUN
  } state_t;

  state_t                 state, nstate;
  logic [4:0]             cnt, ncnt;
  logic [FRAME_LEN-1:0]   shreg, nsh;
  logic [DATA_W-1:0]      ndout;
  logic                   nvalid, nerr;
  logic [15:0]            nfcnt;
  logic [FRAME_LEN-1:0]   shifted;

  assign shifted = (shreg << 1) | FRAME_LEN'(sdi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= nstate;
      cnt        <= ncnt;
      shreg      <= nsh;
      data_out   <= ndout;
      data_valid <= nvalid;
      frame_err  <= nerr;
      frame_cnt  <= nfcnt;
      busy       <= (nstate != IDLE);
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    nsh    = shreg;
    ndout  = data_out;
    nvalid = 1'b0;
    nerr   = 1'b0;
    nfcnt  = frame_cnt;
    unique case (state)
      IDLE: begin
        if (!sync) begin
          nstate = SHIFT;
          ncnt   = 5'd1;
          nsh    = shifted;
        end
      end
      SHIFT: begin
        if (!sync) begin
          if (cnt == LEN5) begin
            nstate = OVERRUN;
            nerr   = 1'b1;
          end else begin
            nsh  = shifted;
            ncnt = (cnt == 5'h1f) ? cnt : cnt + 5'd1;
          end
        end else begin
          nstate = IDLE;
          ncnt   = '0;
          if (cnt == LEN5) begin
`ifdef SER_RX_CTRL_CHECK_EN
            if (shreg[FRAME_LEN-1:DATA_W] != '0) begin
              nerr = 1'b1;
            end else begin
              ndout  = shreg[DATA_W-1:0];
              nvalid = 1'b1;
              nfcnt  = frame_cnt + 16'd1;
            end
`else
            ndout  = shreg[DATA_W-1:0];
            nvalid = 1'b1;
            nfcnt  = frame_cnt + 16'd1;
`endif
          end else begin
            nerr = 1'b1;
          end
        end
      end
      OVERRUN: begin
        if (sync) begin
          nstate = IDLE;
          ncnt   = '0;
        end
      end
      default: begin
        nstate = IDLE;
        ncnt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ser_rx.sv
// Directed bench for ser_rx: full, short, overrun, back-to-back, mid-frame reset, pad bits.
module tb_ser_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sdi = 1'b0;
  logic        sync = 1'b1;
  logic [15:0] data_out;
  logic        data_valid;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int t1;

  ser_rx #(.DATA_W(16), .PAD_BITS(2)) dut (
    .clk(clk),
    .rst(rst),
    .sdi(sdi),
    .sync(sync),
    .data_out(data_out),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .frame_cnt(frame_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic d);
    @(negedge clk);
    sync = s;
    sdi  = d;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic lows(input logic [17:0] bits, input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, (i < 18) ? bits[17-i] : 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sync = 1'b1;
    rst  = 1'b1;
    #2;
    rst  = 1'b0;
  endtask

  initial begin
    // reset state (checked while rst is asserted, no clock edge yet)
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_dout", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    chk("rst_cnt", 32'(frame_cnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    #2;
    rst = 1'b0;
    cyc(1'b1, 1'b0);

    // good frame 00 + A5C3
    lows({2'b00, 16'hA5C3}, 1);
    chk("f1_busy", 32'(busy), 32'h1);
    lows({2'b00, 16'hA5C3} << 1, 17);
    chk("f1_novalid", 32'(data_valid), 32'h0);
    cyc(1'b1, 1'b0);
    chk("f1_valid", 32'(data_valid), 32'h1);
    chk("f1_dout", 32'(data_out), 32'hA5C3);
    chk("f1_cnt", 32'(frame_cnt), 32'h1);
    chk("f1_err", 32'(frame_err), 32'h0);
    chk("f1_idle", 32'(busy), 32'h0);
    cyc(1'b1, 1'b0);
    chk("f1_pulse", 32'(data_valid), 32'h0);

    // short frame
    lows(18'h3FFFF, 10);
    cyc(1'b1, 1'b0);
    chk("sh_err", 32'(frame_err), 32'h1);
    chk("sh_valid", 32'(data_valid), 32'h0);
    chk("sh_dout", 32'(data_out), 32'hA5C3);
    chk("sh_cnt", 32'(frame_cnt), 32'h1);
    cyc(1'b1, 1'b0);
    chk("sh_pulse", 32'(frame_err), 32'h0);

    // overrun
    lows(18'h15555, 18);
    chk("ov_err18", 32'(frame_err), 32'h0);
    cyc(1'b0, 1'b1);
    chk("ov_err19", 32'(frame_err), 32'h1);
    chk("ov_busy19", 32'(busy), 32'h1);
    cyc(1'b0, 1'b1);
    chk("ov_err20", 32'(frame_err), 32'h0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("ov_busy22", 32'(busy), 32'h1);
    cyc(1'b1, 1'b0);
    chk("ov_end_err", 32'(frame_err), 32'h0);
    chk("ov_end_valid", 32'(data_valid), 32'h0);
    chk("ov_end_busy", 32'(busy), 32'h0);
    chk("ov_dout", 32'(data_out), 32'hA5C3);

    // back-to-back frames from a fresh reset
    do_reset();
    lows({2'b00, 16'h1234}, 18);
    cyc(1'b1, 1'b0);
    chk("bb_v1", 32'(data_valid), 32'h1);
    chk("bb_d1", 32'(data_out), 32'h1234);
    t1 = cycle;
    lows({2'b00, 16'hFFFF}, 18);
    cyc(1'b1, 1'b0);
    chk("bb_v2", 32'(data_valid), 32'h1);
    chk("bb_gap", 32'(cycle - t1), 32'd19);
    chk("bb_d2", 32'(data_out), 32'hFFFF);
    chk("bb_cnt", 32'(frame_cnt), 32'h2);

    // reset in the middle of a frame
    lows({2'b00, 16'h5555}, 9);
    rst = 1'b1;
    #1;
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_dout", 32'(data_out), 32'h0);
    chk("mr_cnt", 32'(frame_cnt), 32'h0);
    #1;
    rst = 1'b0;
    lows({2'b00, 16'h0F0F}, 18);
    chk("mr_noerr", 32'(frame_err), 32'h0);
    cyc(1'b1, 1'b0);
    chk("mr_valid", 32'(data_valid), 32'h1);
    chk("mr_dout2", 32'(data_out), 32'h0F0F);
    chk("mr_cnt2", 32'(frame_cnt), 32'h1);

    // nonzero pad bits
    lows({2'b01, 16'hBEEF}, 18);
    cyc(1'b1, 1'b0);
`ifdef SER_RX_CTRL_CHECK_EN
    chk("pad_err", 32'(frame_err), 32'h1);
    chk("pad_valid", 32'(data_valid), 32'h0);
    chk("pad_dout", 32'(data_out), 32'h0F0F);
    chk("pad_cnt", 32'(frame_cnt), 32'h1);
`else
    chk("pad_err", 32'(frame_err), 32'h0);
    chk("pad_valid", 32'(data_valid), 32'h1);
    chk("pad_dout", 32'(data_out), 32'hBEEF);
    chk("pad_cnt", 32'(frame_cnt), 32'h2);
`endif
    cyc(1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ser_rx.md
SER_RX -- requirements
Module: ser_rx

Interface
REQ-001 Parameter: DATA_W, 16, payload width in bits, MSB first.
REQ-002 Parameter: PAD_BITS, 2, leading control/pad bits per frame, expected value 0.
REQ-003 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: sdi  input  1  serial data, sampled on clk rising edge.
REQ-006 Port: sync  input  1  frame strobe, active-low; a frame is a contiguous run of low samples.
REQ-007 Port: data_out  output  DATA_W  last good payload, held between frames.
REQ-008 Port: data_valid  output  1  one-cycle pulse when data_out is updated.
REQ-009 Port: frame_err  output  1  one-cycle pulse on a short or overrun frame.
REQ-010 Port: frame_cnt  output  16  count of good frames, wraps 0xFFFF->0x0000.
REQ-011 Port: busy  output  1  high while in SHIFT or OVERRUN.

Function
REQ-012 Frame length FRAME_LEN = PAD_BITS + DATA_W (18 by default); bit counter 5 bits wide, saturating.
REQ-013 States: IDLE, SHIFT, OVERRUN; IDLE after reset.
REQ-014 IDLE: sync sampled low -> SHIFT, counter=1, first sample (sdi) shifted in.
REQ-015 SHIFT: each low sample shifts sdi into the LSB of the FRAME_LEN-bit shift register and increments the counter.
REQ-016 SHIFT, sync low with counter == FRAME_LEN -> OVERRUN, frame_err pulses next edge, no data update.
REQ-017 SHIFT, sync high with counter == FRAME_LEN -> IDLE, data_out <= low DATA_W bits of the shift register, data_valid=1 for one cycle, frame_cnt+1.
REQ-018 SHIFT, sync high with counter < FRAME_LEN -> IDLE, frame_err=1 for one cycle, data_out and frame_cnt unchanged.
REQ-019 OVERRUN: ignore sdi; sync high -> IDLE with no further pulse.
REQ-020 Commit latency: data_valid and new data_out are visible right after the edge that samples the first high sync following a frame.
REQ-021 Back-to-back: a single high sample between frames is sufficient. That sample commits the old frame; a low sample on the next edge starts the new frame from IDLE.
REQ-022 data_valid and frame_err are never high in the same cycle.
REQ-023 busy = (state != IDLE), registered.

Reset
REQ-024 rst high asynchronously forces IDLE, counter=0, shift register=0, data_out=0, data_valid=0, frame_err=0, frame_cnt=0, busy=0.
REQ-025 Reset mid-frame discards the partial frame. After release, the first low sync sample starts a new frame.

Configuration
REQ-026 Macro SER_RX_CTRL_CHECK_EN defined: on a full-length commit (REQ-017), nonzero pad bits produce a frame_err pulse instead of data_valid. data_out and frame_cnt are left unchanged.
REQ-027 Macro SER_RX_CTRL_CHECK_EN undefined: pad bits are shifted in and discarded, and never affect outputs.

Verification
REQ-028 sync low 18 cycles, sdi = 00 then 0xA5C3 MSB first, then sync high -> data_valid one cycle, data_out=0xA5C3, frame_cnt=1, frame_err=0.
REQ-029 sync low 10 cycles then high -> frame_err one cycle, data_valid=0, data_out and frame_cnt unchanged.
REQ-030 sync low 22 cycles -> frame_err one cycle after the 19th low sample, busy high until sync high, no data_valid.
REQ-031 Two frames 0x1234, 0xFFFF separated by one high cycle -> two data_valid pulses 19 cycles apart, data_out ends 0xFFFF, frame_cnt=2.
REQ-032 rst pulse after the 9th low sample, then a full 0x0F0F frame -> no output from the aborted frame, data_out=0x0F0F, frame_cnt=1.
REQ-033 With SER_RX_CTRL_CHECK_EN: pad bits 01 plus 0xBEEF -> frame_err, data_out unchanged. Without the macro, the same stimulus gives data_valid with data_out=0xBEEF.
